// File: rtl/gobang_pkg.sv
// gobang_pkg: board geometry and cell encoding shared by the GoBang datapath.
// Rev 1.0
`default_nettype none

package gobang_pkg;
   localparam int BOARD_N    = 15;
   localparam int COORD_W    = 4;
   localparam int CENTER     = BOARD_N / 2;
   localparam int MAX_STONES = BOARD_N * BOARD_N;

   typedef logic [1:0] cell_t;

   localparam cell_t EMPTY = 2'd0;
   localparam cell_t BLACK = 2'd1;
   localparam cell_t WHITE = 2'd2;
endpackage

`default_nettype wire

// File: rtl/gobang_board_datapath_key_edge.sv
// key_edge: falling-edge detector for an active-low, already synchronised key.
// Rev 1.0
`default_nettype none

module key_edge (
   input  logic clock,
   input  logic resetn,
   input  logic key,
   output logic press
);
   logic r_prev;

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) r_prev <= 1'b1;
      else         r_prev <= key;
   end

   assign press = r_prev & ~key;
endmodule

`default_nettype wire

// File: rtl/gobang_board_datapath.sv
// gobang_board_datapath: cursor pointer, board storage, legality flag and side to move.
// Rev 1.0
`default_nettype none

module gobang_board_datapath #(
   parameter int BOARD_N = 15,
   parameter int COORD_W = 4
) (
   input  logic               clock,
   input  logic               resetn,
   input  logic               change_able_read,
   input  logic               change_turn,
   input  logic               control_set,
   input  logic               put,
   input  logic               key_up,
   input  logic               key_down,
   input  logic               key_left,
   input  logic               key_right,
   output logic [COORD_W-1:0] ptr_x,
   output logic [COORD_W-1:0] ptr_y,
   output logic               player,
   output logic               last_legal,
   output logic [7:0]         stone_count,
   output logic               board_full,
   input  logic [COORD_W-1:0] rd_x,
   input  logic [COORD_W-1:0] rd_y,
   output logic [1:0]         rd_data
);
   import gobang_pkg::*;

   localparam int                 CELLS      = BOARD_N * BOARD_N;
   localparam logic [COORD_W-1:0] PTR_CENTER = COORD_W'(BOARD_N / 2);
   localparam logic [COORD_W-1:0] PTR_LAST   = COORD_W'(BOARD_N - 1);
   localparam logic [COORD_W-1:0] PTR_ONE    = COORD_W'(1);
   localparam logic [7:0]         ROW_LEN    = 8'(BOARD_N);
   localparam logic [7:0]         COUNT_MAX  = 8'(CELLS);

   logic               w_press_up, w_press_down, w_press_left, w_press_right;
   logic [COORD_W-1:0] r_x, r_y, w_x_next, w_y_next;
   logic               r_player, r_legal, r_full;
   logic [7:0]         r_count;
   cell_t              r_cells [CELLS];
   logic [7:0]         w_wr_idx, w_rd_idx;
   logic               w_put_req, w_put_ok;

   key_edge u_edge_up    (.clock(clock), .resetn(resetn), .key(key_up),    .press(w_press_up));
   key_edge u_edge_down  (.clock(clock), .resetn(resetn), .key(key_down),  .press(w_press_down));
   key_edge u_edge_left  (.clock(clock), .resetn(resetn), .key(key_left),  .press(w_press_left));
   key_edge u_edge_right (.clock(clock), .resetn(resetn), .key(key_right), .press(w_press_right));

   // Opposite presses on one axis cancel; recentring beats any move.
   always_comb begin
      w_x_next = r_x;
      w_y_next = r_y;
      if (control_set) begin
         w_x_next = PTR_CENTER;
         w_y_next = PTR_CENTER;
      end else if (change_able_read) begin
         if (w_press_left && !w_press_right)
            w_x_next = (r_x == '0) ? PTR_LAST : r_x - PTR_ONE;
         else if (w_press_right && !w_press_left)
            w_x_next = (r_x == PTR_LAST) ? '0 : r_x + PTR_ONE;
         if (w_press_up && !w_press_down)
            w_y_next = (r_y == '0) ? PTR_LAST : r_y - PTR_ONE;
         else if (w_press_down && !w_press_up)
            w_y_next = (r_y == PTR_LAST) ? '0 : r_y + PTR_ONE;
      end
   end

   assign w_wr_idx  = 8'(r_y) * ROW_LEN + 8'(r_x);
   assign w_put_req = change_able_read & ~put;
   assign w_put_ok  = w_put_req & (r_cells[w_wr_idx] == EMPTY);

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_x <= PTR_CENTER;
         r_y <= PTR_CENTER;
      end else begin
         r_x <= w_x_next;
         r_y <= w_y_next;
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         for (int i = 0; i < CELLS; i++) r_cells[i] <= EMPTY;
      end else if (w_put_ok) begin
         r_cells[w_wr_idx] <= r_player ? WHITE : BLACK;
      end
   end

   // A put result written this cycle takes precedence over a turn-change clear.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_player <= 1'b0;
         r_legal  <= 1'b0;
         r_count  <= 8'd0;
         r_full   <= 1'b0;
      end else begin
         if (change_turn && r_legal) begin
            r_player <= ~r_player;
            r_legal  <= 1'b0;
         end
         if (w_put_req) r_legal <= w_put_ok;
         if (w_put_ok && r_count != COUNT_MAX) r_count <= r_count + 8'd1;
         r_full <= (r_count == COUNT_MAX);
      end
   end

   assign w_rd_idx = 8'(rd_y) * ROW_LEN + 8'(rd_x);
   assign rd_data  = (int'(rd_x) >= BOARD_N || int'(rd_y) >= BOARD_N) ? EMPTY : r_cells[w_rd_idx];

   assign ptr_x       = r_x;
   assign ptr_y       = r_y;
   assign player      = r_player;
   assign last_legal  = r_legal;
   assign stone_count = r_count;
   assign board_full  = r_full;
endmodule

`default_nettype wire

// File: tb/tb_gobang_board_datapath.sv
// tb_gobang_board_datapath: directed plus random stimulus against a board-level reference model.
// Rev 1.0
`default_nettype none

module tb_gobang_board_datapath;
   localparam int BN = 15;

   logic       clock = 1'b0;
   logic       resetn = 1'b0;
   logic       change_able_read = 1'b0, change_turn = 1'b0, control_set = 1'b0;
   logic       put = 1'b1;
   logic       key_up = 1'b1, key_down = 1'b1, key_left = 1'b1, key_right = 1'b1;
   logic [3:0] ptr_x, ptr_y, rd_x = 4'd0, rd_y = 4'd0;
   logic       player, last_legal, board_full;
   logic [7:0] stone_count;
   logic [1:0] rd_data;

   int n_vec = 0;
   int n_err = 0;

   // reference model state
   int m_x, m_y, m_player, m_legal, m_count, m_full;
   int mb [BN][BN];
   int kp_up, kp_down, kp_left, kp_right;

   gobang_board_datapath #(.BOARD_N(15), .COORD_W(4)) dut (
      .clock(clock), .resetn(resetn),
      .change_able_read(change_able_read), .change_turn(change_turn), .control_set(control_set),
      .put(put), .key_up(key_up), .key_down(key_down), .key_left(key_left), .key_right(key_right),
      .ptr_x(ptr_x), .ptr_y(ptr_y), .player(player), .last_legal(last_legal),
      .stone_count(stone_count), .board_full(board_full),
      .rd_x(rd_x), .rd_y(rd_y), .rd_data(rd_data)
   );

   always #10 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: observed %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_x = BN / 2; m_y = BN / 2;
      m_player = 0; m_legal = 0; m_count = 0; m_full = 0;
      kp_up = 1; kp_down = 1; kp_left = 1; kp_right = 1;
      for (int x = 0; x < BN; x++)
         for (int y = 0; y < BN; y++) mb[x][y] = 0;
   endtask

   // One clock edge of game rules, using the inputs present at that edge.
   task automatic model_step();
      int pu, pd, pl, pr, old_legal, old_count, old_player;
      pu = kp_up & (key_up ? 0 : 1);     kp_up = int'(key_up);
      pd = kp_down & (key_down ? 0 : 1); kp_down = int'(key_down);
      pl = kp_left & (key_left ? 0 : 1); kp_left = int'(key_left);
      pr = kp_right & (key_right ? 0 : 1); kp_right = int'(key_right);
      old_legal = m_legal; old_count = m_count; old_player = m_player;
      m_full = (old_count == BN * BN) ? 1 : 0;
      if (change_turn && old_legal == 1) begin
         m_player = 1 - old_player;
         m_legal = 0;
      end
      if (change_able_read && !put) begin
         if (mb[m_x][m_y] == 0) begin
            mb[m_x][m_y] = (old_player == 1) ? 2 : 1;
            m_legal = 1;
            if (m_count < BN * BN) m_count++;
         end else begin
            m_legal = 0;
         end
      end
      if (control_set) begin
         m_x = BN / 2; m_y = BN / 2;
      end else if (change_able_read) begin
         m_x = (m_x + pr - pl + BN) % BN;
         m_y = (m_y + pd - pu + BN) % BN;
      end
   endtask

   task automatic rd_check(input string tag, input int x, input int y, input int exp);
      rd_x = 4'(x); rd_y = 4'(y);
      #1;
      check(tag, 32'(rd_data), exp);
   endtask

   task automatic check_all();
      int rx, ry;
      check("ptr_x", 32'(ptr_x), m_x);
      check("ptr_y", 32'(ptr_y), m_y);
      check("player", 32'(player), m_player);
      check("last_legal", 32'(last_legal), m_legal);
      check("stone_count", 32'(stone_count), m_count);
      check("board_full", 32'(board_full), m_full);
      rx = $urandom_range(0, 15); ry = $urandom_range(0, 15);
      rd_check("rd_data", rx, ry, (rx < BN && ry < BN) ? mb[rx][ry] : 0);
   endtask

   task automatic tick();
      @(posedge clock);
      model_step();
      #1;
      check_all();
   endtask

   task automatic set_key(input int k, input logic v);
      case (k)
         0: key_up = v;
         1: key_down = v;
         2: key_left = v;
         default: key_right = v;
      endcase
   endtask

   task automatic press(input int k, input int n);
      repeat (n) begin
         set_key(k, 1'b0); tick();
         set_key(k, 1'b1); tick();
      end
   endtask

   task automatic do_reset();
      change_able_read = 0; change_turn = 0; control_set = 0; put = 1;
      key_up = 1; key_down = 1; key_left = 1; key_right = 1;
      resetn = 0;
      #1;
      model_reset();
      repeat (2) @(posedge clock);
      #1;
      resetn = 1;
   endtask

   initial begin
      model_reset();
      do_reset();
      check("rst ptr_x", 32'(ptr_x), 7);
      check("rst ptr_y", 32'(ptr_y), 7);
      check("rst player", 32'(player), 0);
      check("rst count", 32'(stone_count), 0);
      rd_check("rst cell77", 7, 7, 0);
      rd_check("rst cell00", 0, 0, 0);

      // pointer wrap and single step per press
      change_able_read = 1;
      press(2, 8);
      check("wrap left", 32'(ptr_x), 14);
      press(3, 1);
      check("wrap right", 32'(ptr_x), 0);
      key_left = 0;
      repeat (20) tick();
      key_left = 1; tick();
      check("hold left", 32'(ptr_x), 14);
      control_set = 1; tick(); control_set = 0;

      // legal put then turn change
      put = 0; tick(); put = 1;
      rd_check("put77", 7, 7, 1);
      check("put legal", 32'(last_legal), 1);
      check("put count", 32'(stone_count), 1);
      change_able_read = 0; change_turn = 1; control_set = 1; tick();
      change_turn = 0; control_set = 0;
      check("turn player", 32'(player), 1);
      check("turn legal", 32'(last_legal), 0);

      // illegal put on occupied cell
      change_able_read = 1;
      put = 0; tick(); put = 1;
      rd_check("occ77", 7, 7, 1);
      check("occ legal", 32'(last_legal), 0);
      check("occ count", 32'(stone_count), 1);
      change_able_read = 0; change_turn = 1; tick(); change_turn = 0;
      check("noturn player", 32'(player), 1);

      // opposite keys cancel, recentre beats a move
      change_able_read = 1;
      press(2, 4); press(0, 3);
      check("to x3", 32'(ptr_x), 3);
      check("to y4", 32'(ptr_y), 4);
      key_up = 0; key_down = 0; tick(); key_up = 1; key_down = 1; tick();
      check("cancel y", 32'(ptr_y), 4);
      control_set = 1; key_right = 0; tick(); control_set = 0; key_right = 1; tick();
      check("ctl x", 32'(ptr_x), 7);
      check("ctl y", 32'(ptr_y), 7);

      // reset landing on a write cycle
      press(2, 5); press(0, 5);
      put = 0;
      #3 resetn = 0;
      #1 model_reset();
      check("midrst count", 32'(stone_count), 0);
      @(posedge clock); #1;
      rd_check("midrst cell22", 2, 2, 0);
      rd_check("midrst cell77", 7, 7, 0);
      check("midrst ptr_x", 32'(ptr_x), 7);
      check("midrst player", 32'(player), 0);
      put = 1; change_able_read = 0;
      resetn = 1;

      // random traffic
      for (int i = 0; i < 400; i++) begin
         change_able_read = ($urandom_range(0, 3) != 0);
         key_up    = ($urandom_range(0, 3) != 0);
         key_down  = ($urandom_range(0, 3) != 0);
         key_left  = ($urandom_range(0, 3) != 0);
         key_right = ($urandom_range(0, 3) != 0);
         put         = ($urandom_range(0, 5) != 0);
         change_turn = ($urandom_range(0, 7) == 0);
         control_set = ($urandom_range(0, 15) == 0);
         tick();
      end

      // fill the whole board
      do_reset();
      change_able_read = 1;
      for (int i = 0; i < BN * BN; i++) begin
         put = 0; tick(); put = 1;
         if (i == BN * BN - 1) begin
            check("fill count", 32'(stone_count), 225);
            check("fill full early", 32'(board_full), 0);
            tick();
            check("fill full", 32'(board_full), 1);
         end else if ((i % BN) == BN - 1) begin
            press(1, 1);
         end else begin
            press(3, 1);
         end
      end
      put = 0; tick(); put = 1;
      check("sat count", 32'(stone_count), 225);
      check("sat legal", 32'(last_legal), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

`default_nettype wire
